// File: rtl/dispatch_unit_pkg.sv
// Shared types and constants for the dispatch stage: payload field widths,
// functional-unit class indices and the packed buffer entry.
package dispatch_unit_pkg;

  localparam int ROB_ID_W   = 5;
  localparam int PHY_ADDR_W = 6;
  localparam int UOP_W      = 6;
  localparam int XLEN       = 32;

  localparam int FU_ALU    = 0;
  localparam int FU_MDU    = 1;
  localparam int FU_BRANCH = 2;
  localparam int FU_LSU    = 3;
  localparam int FU_CSR    = 4;
  localparam int FU_MISC   = 5;
  localparam int FU_RSVD   = 6;

  typedef struct packed {
    logic [UOP_W-1:0]      uop;
    logic [XLEN-1:0]       immediate;
    logic [XLEN-1:0]       pc;
    logic [ROB_ID_W-1:0]   rob_id;
    logic [PHY_ADDR_W-1:0] rs1_phy;
    logic [PHY_ADDR_W-1:0] rs2_phy;
    logic [PHY_ADDR_W-1:0] rd_phy;
  } dispatch_entry_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Circular dispatch buffer: entry storage, head/tail pointers and occupancy.
// Callers guarantee enq_i only when not full and deq_i only when not empty.
module dispatch_fifo
  import dispatch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NFU   = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         enq_i,
  input  logic [NFU-1:0]               enq_futype_i,
  input  dispatch_entry_t              enq_entry_i,
  input  logic                         deq_i,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [NFU-1:0]               head_futype_o,
  output dispatch_entry_t              head_entry_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [NFU-1:0]   futype_mem_q [DEPTH];
  dispatch_entry_t  entry_mem_q  [DEPTH];

  // Next-state pointers and count; flush wins over any same-cycle transfer.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_i) begin
        tail_d = tail_q + PTR_W'(1'b1);
      end else begin
        tail_d = tail_q;
      end
      if (deq_i) begin
        head_d = head_q + PTR_W'(1'b1);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + {{PTR_W{1'b0}}, enq_i} - {{PTR_W{1'b0}}, deq_i};
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (enq_i && !flush_i) begin
      futype_mem_q[tail_q] <= enq_futype_i;
      entry_mem_q[tail_q]  <= enq_entry_i;
    end
  end

  assign count_o       = count_q;
  assign head_futype_o = futype_mem_q[head_q];
  assign head_entry_o  = entry_mem_q[head_q];

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: buffers renamed uops in order and offers the head uop to
// the functional-unit class selected by the lowest set bit of its futype.
module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NFU   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  dispatch_ready,
  input  logic [NFU-1:0]        in_futype,
  input  logic [UOP_W-1:0]      in_uop,
  input  logic [XLEN-1:0]       in_immediate,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [ROB_ID_W-1:0]   in_rob_id,
  input  logic [PHY_ADDR_W-1:0] in_rs1_phy,
  input  logic [PHY_ADDR_W-1:0] in_rs2_phy,
  input  logic [PHY_ADDR_W-1:0] in_rd_phy,
  output logic [NFU-1:0]        fu_valid,
  input  logic [NFU-1:0]        fu_ready,
  output logic [UOP_W-1:0]      fu_uop,
  output logic [XLEN-1:0]       fu_immediate,
  output logic [XLEN-1:0]       fu_pc,
  output logic [ROB_ID_W-1:0]   fu_rob_id,
  output logic [PHY_ADDR_W-1:0] fu_rs1_phy,
  output logic [PHY_ADDR_W-1:0] fu_rs2_phy,
  output logic [PHY_ADDR_W-1:0] fu_rd_phy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count_s;
  logic [NFU-1:0]   head_futype_s;
  dispatch_entry_t  head_entry_s;
  dispatch_entry_t  in_entry_s;
  logic [NFU-1:0]   class_sel_s;
  logic             has_entry_s;
  logic             enq_s;
  logic             deq_s;
  logic             found_s;

  assign in_entry_s = '{uop:       in_uop,
                        immediate: in_immediate,
                        pc:        in_pc,
                        rob_id:    in_rob_id,
                        rs1_phy:   in_rs1_phy,
                        rs2_phy:   in_rs2_phy,
                        rd_phy:    in_rd_phy};

  // Lowest-set-bit class select; multi-bit and reserved-class futypes share the rule.
  always_comb begin
    class_sel_s = '0;
    found_s     = 1'b0;
    for (int k = 0; k < NFU; k++) begin
      if (!found_s && head_futype_s[k]) begin
        class_sel_s[k] = 1'b1;
        found_s        = 1'b1;
      end else begin
        class_sel_s[k] = 1'b0;
      end
    end
  end

  // Handshake: a futype of zero carries no work and retires from the head unoffered.
  always_comb begin
    has_entry_s    = (count_s != {CNT_W{1'b0}});
    dispatch_ready = (count_s != CNT_W'(DEPTH));
    enq_s          = in_valid && dispatch_ready && !flush;
    if (has_entry_s && !flush) begin
      fu_valid = class_sel_s;
      deq_s    = ((class_sel_s & fu_ready) != '0) || (head_futype_s == '0);
    end else begin
      fu_valid = '0;
      deq_s    = 1'b0;
    end
  end

  dispatch_fifo #(
    .DEPTH (DEPTH),
    .NFU   (NFU)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .enq_i         (enq_s),
    .enq_futype_i  (in_futype),
    .enq_entry_i   (in_entry_s),
    .deq_i         (deq_s),
    .count_o       (count_s),
    .head_futype_o (head_futype_s),
    .head_entry_o  (head_entry_s)
  );

  assign fu_uop       = head_entry_s.uop;
  assign fu_immediate = head_entry_s.immediate;
  assign fu_pc        = head_entry_s.pc;
  assign fu_rob_id    = head_entry_s.rob_id;
  assign fu_rs1_phy   = head_entry_s.rs1_phy;
  assign fu_rs2_phy   = head_entry_s.rs2_phy;
  assign fu_rd_phy    = head_entry_s.rd_phy;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed scenarios followed by random traffic, all checked against a
// queue-based reference model of the dispatch buffer.
module tb_dispatch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        dispatch_ready;
  logic [6:0]  in_futype;
  logic [5:0]  in_uop;
  logic [31:0] in_immediate;
  logic [31:0] in_pc;
  logic [4:0]  in_rob_id;
  logic [5:0]  in_rs1_phy;
  logic [5:0]  in_rs2_phy;
  logic [5:0]  in_rd_phy;
  logic [6:0]  fu_valid;
  logic [6:0]  fu_ready;
  logic [5:0]  fu_uop;
  logic [31:0] fu_immediate;
  logic [31:0] fu_pc;
  logic [4:0]  fu_rob_id;
  logic [5:0]  fu_rs1_phy;
  logic [5:0]  fu_rs2_phy;
  logic [5:0]  fu_rd_phy;

  typedef struct packed {
    logic [6:0]  ft;
    logic [92:0] pay;
  } model_t;

  model_t     mq[$];
  int         tests;
  int         fails;
  logic [4:0] rob_ctr;

  dispatch_unit #(.DEPTH(DEPTH), .NFU(7)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .dispatch_ready(dispatch_ready), .in_futype(in_futype), .in_uop(in_uop),
    .in_immediate(in_immediate), .in_pc(in_pc), .in_rob_id(in_rob_id),
    .in_rs1_phy(in_rs1_phy), .in_rs2_phy(in_rs2_phy), .in_rd_phy(in_rd_phy),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_uop(fu_uop),
    .fu_immediate(fu_immediate), .fu_pc(fu_pc), .fu_rob_id(fu_rob_id),
    .fu_rs1_phy(fu_rs1_phy), .fu_rs2_phy(fu_rs2_phy), .fu_rd_phy(fu_rd_phy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] lowbit(input logic [6:0] x);
    return x & (~x + 7'd1);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [6:0] ft);
    in_valid     = v;
    in_futype    = ft;
    in_uop       = 6'($urandom);
    in_immediate = $urandom;
    in_pc        = $urandom;
    in_rob_id    = rob_ctr;
    in_rs1_phy   = 6'($urandom);
    in_rs2_phy   = 6'($urandom);
    in_rd_phy    = 6'($urandom);
    if (v) rob_ctr = rob_ctr + 5'd1;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    logic [6:0] exp_fv;
    logic       do_deq;
    logic       do_enq;
    model_t     e;
    @(negedge clk);
    exp_fv = (mq.size() > 0 && !flush) ? lowbit(mq[0].ft) : 7'd0;
    chk("dispatch_ready", 128'(dispatch_ready), 128'(mq.size() != DEPTH));
    chk("fu_valid", 128'(fu_valid), 128'(exp_fv));
    if (mq.size() > 0)
      chk("payload", 128'({fu_uop, fu_immediate, fu_pc, fu_rob_id, fu_rs1_phy, fu_rs2_phy, fu_rd_phy}),
          128'(mq[0].pay));
    do_deq = (mq.size() > 0) && !flush && ((mq[0].ft == 7'd0) || ((exp_fv & fu_ready) != 7'd0));
    do_enq = in_valid && (mq.size() != DEPTH) && !flush;
    e.ft   = in_futype;
    e.pay  = {in_uop, in_immediate, in_pc, in_rob_id, in_rs1_phy, in_rs2_phy, in_rd_phy};
    @(posedge clk);
    if (!rst || flush) begin
      mq.delete();
    end else begin
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back(e);
    end
    #1;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rob_ctr  = 5'd0;
    rst      = 1'b0;
    flush    = 1'b0;
    fu_ready = 7'd0;
    set_in(1'b0, 7'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state, then single uop to ALU with 1-cycle latency.
    set_in(1'b1, 7'b0000001);
    in_pc = 32'h1c000000;
    cycle();
    set_in(1'b0, 7'd0);
    fu_ready = 7'b0000001;
    chk("req031_fu_valid", 128'(fu_valid), 128'(7'b0000001));
    chk("req031_fu_pc", 128'(fu_pc), 128'(32'h1c000000));
    cycle();
    chk("req031_empty", 128'(fu_valid), 128'(7'd0));
    cycle();

    // Fill with nothing accepted, overflow attempt, then drain in order.
    rob_ctr  = 5'd0;
    fu_ready = 7'd0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 7'(1 << $urandom_range(0, 6)));
      cycle();
    end
    chk("req032_full", 128'(dispatch_ready), 128'(1'b0));
    set_in(1'b0, 7'd0);
    fu_ready = 7'h7f;
    for (int i = 0; i < 4; i++) begin
      chk("req032_rob_order", 128'(fu_rob_id), 128'(i));
      cycle();
    end
    chk("req032_drained", 128'(fu_valid), 128'(7'd0));

    // Full buffer: enqueue attempt with simultaneous dequeue is rejected.
    fu_ready = 7'd0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 7'b0000010);
      cycle();
    end
    set_in(1'b1, 7'b0000001);
    fu_ready = 7'h7f;
    cycle();
    set_in(1'b0, 7'd0);
    fu_ready = 7'd0;
    chk("req033_ready_after", 128'(dispatch_ready), 128'(1'b1));
    cycle();
    fu_ready = 7'h7f;
    repeat (4) cycle();

    // Load/store head stalls while its class is not ready.
    set_in(1'b1, 7'b0001000);
    fu_ready = 7'b1110111;
    cycle();
    set_in(1'b0, 7'd0);
    repeat (5) begin
      chk("req034_hold", 128'(fu_valid), 128'(7'b0001000));
      cycle();
    end
    fu_ready = 7'h7f;
    cycle();

    // Flush with three buffered uops and a same-cycle enqueue.
    fu_ready = 7'd0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 7'b0000100);
      cycle();
    end
    set_in(1'b1, 7'b0000001);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(1'b0, 7'd0);
    chk("req035_flushed", 128'(fu_valid), 128'(7'd0));
    cycle();

    // Exception-only uop drops silently ahead of a MISC uop.
    set_in(1'b1, 7'b0000000);
    cycle();
    set_in(1'b1, 7'b0100000);
    chk("req036_no_valid", 128'(fu_valid), 128'(7'd0));
    cycle();
    set_in(1'b0, 7'd0);
    chk("req036_misc", 128'(fu_valid), 128'(7'b0100000));
    cycle();
    cycle();

    // Reset mid-operation with flush and in_valid asserted.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 7'b1010000);
      cycle();
    end
    rst   = 1'b0;
    flush = 1'b1;
    set_in(1'b1, 7'b0000001);
    cycle();
    rst   = 1'b1;
    flush = 1'b0;
    set_in(1'b0, 7'd0);
    chk("reset_mid_empty", 128'(fu_valid), 128'(7'd0));
    cycle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [6:0] ft;
      case ($urandom_range(0, 7))
        0:       ft = 7'd0;
        1:       ft = 7'($urandom);
        default: ft = 7'(1 << $urandom_range(0, 6));
      endcase
      set_in(1'($urandom_range(0, 1)), ft);
      fu_ready = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'($urandom & $urandom);
      flush    = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dispatch_unit.md
DISPATCH_UNIT -- requirements
Module: dispatch_unit

Interface
REQ-001 Parameter DEPTH, default 4: dispatch buffer entries; power of two, at least 2.
REQ-002 Parameter NFU, default 7: functional-unit classes. Bit 0 alu, 1 mdu, 2 branch, 3 load/store, 4 CSR, 5 MISC, 6 reserved.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low (rst==0 at a clk edge resets).
REQ-005 flush  in  1  pipeline flush; discard all buffered uops.
REQ-006 in_valid  in  1  decode/rename/ROB deliver one uop this cycle.
REQ-007 dispatch_ready  out  1  buffer can accept one uop this cycle.
REQ-008 in_futype  in  NFU  one-hot FU class.
REQ-009 in_uop  in  6  micro-op code.
REQ-010 in_immediate, in_pc  in  32 each  immediate and instruction PC.
REQ-011 in_rob_id  in  ROB_ID_W  ROB slot.
REQ-012 in_rs1_phy, in_rs2_phy, in_rd_phy  in  PHY_ADDR_W each  renamed registers.
REQ-013 fu_valid  out  NFU  one-hot: head uop offered to FU class k.
REQ-014 fu_ready  in  NFU  per-class issue-queue acceptance.
REQ-015 fu_uop, fu_immediate, fu_pc, fu_rob_id, fu_rs1_phy, fu_rs2_phy, fu_rd_phy  out  same widths as inputs  shared head-entry payload.

Function
REQ-016 Enqueue SHALL occur iff in_valid && dispatch_ready && !flush; the uop is written at the tail, tail pointer advances modulo DEPTH.
REQ-017 dispatch_ready SHALL be (count != DEPTH), driven from registered count only; in_valid while dispatch_ready==0 SHALL be ignored.
REQ-018 Head class SHALL be the lowest set bit of head futype; bit 6 or multiple bits SHALL resolve by lowest-set-bit rule.
REQ-019 fu_valid SHALL be one-hot at the head class when count>0 and !flush; otherwise all zero.
REQ-020 Dequeue SHALL occur when (fu_valid & fu_ready) != 0; head pointer advances modulo DEPTH.
REQ-021 A head entry with futype==0 (exception-only uop) SHALL be dequeued in one cycle with fu_valid all zero.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged; enqueue is permitted when full only if not full at cycle start (no bypass into a full buffer).
REQ-023 Empty buffer: enqueue-to-fu_valid latency SHALL be exactly 1 cycle; no combinational input-to-output path.
REQ-024 Payload outputs SHALL hold head-entry contents whenever count>0, stable while fu_valid held without handshake.
REQ-025 flush SHALL clear count, head, tail at the edge; flush overrides same-cycle enqueue and dequeue.
REQ-026 Program order SHALL be preserved: no uop leaves before an older one.

Reset
REQ-027 On rst==0: count=0, head=0, tail=0; thus dispatch_ready=1, fu_valid=0 next cycle; payload storage not reset.
REQ-028 Reset mid-operation SHALL discard all entries identically to flush; rst has priority over flush and in_valid.

Structure
REQ-029 ROB_ID_W=5, PHY_ADDR_W=6, FU class index constants and a packed dispatch-entry struct SHALL live in the shared common package.
REQ-030 One sub-module, dispatch_fifo (storage, pointers, count), is natural; class select and handshake stay in dispatch_unit.

Verification
REQ-031 Reset, then in_valid=1, futype=0000001, pc=0x1c000000 -> next cycle fu_valid=0000001, fu_pc=0x1c000000; fu_ready[0]=1 -> count 0.
REQ-032 Four uops with all fu_ready=0 -> dispatch_ready=0 after fourth; fifth in_valid ignored; release fu_ready -> four uops out in order, rob_id 0,1,2,3.
REQ-033 Full buffer, same cycle enqueue attempt and dequeue -> enqueue rejected, count 4->3, dispatch_ready=1 next cycle.
REQ-034 Head futype=0001000, fu_ready=1110111 -> fu_valid=0001000 held, payload stable, no dequeue, for 5 cycles.
REQ-035 Three buffered uops, flush=1 with in_valid=1 -> next cycle count=0, fu_valid=0, incoming uop dropped.
REQ-036 Head futype=0000000 followed by futype=0100000 -> first drops in 1 cycle, no fu_valid; second offered fu_valid=0100000.
